inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- PC generation and fetch-queue stage sitting directly upstream of the instruction ROM.
- Drives ROM chip-enable and address, captures the combinationally returned instruction word, and buffers {pc, inst} pairs in a small FIFO.
- Feeds decode through a valid/ready handshake.
- Handles pipeline stall, branch redirect and exception flush.

Parameters:
- DEPTH, 4, fetch-queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/ROM address width (matches InstAddrBus).
- DATA_W, 32, instruction width (matches InstBus).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1'b1).
- stall_i  in  1  pipeline-control stall; freezes PC and fetch.
- flush_i  in  1  exception flush request.
- new_pc_i  in  ADDR_W  exception handler target.
- branch_flag_i  in  1  taken-branch redirect from execute.
- branch_target_addr_i  in  ADDR_W  branch target.
- rom_ce_o  out  1  ROM chip enable (ChipEnable/ChipDisable).
- rom_addr_o  out  ADDR_W  ROM byte address = current PC.
- rom_inst_i  in  DATA_W  ROM instruction, valid in the same cycle as rom_addr_o.
- id_valid_o  out  1  queue head valid.
- id_ready_i  in  1  decode accepts the head.
- id_pc_o  out  ADDR_W  PC of head entry.
- id_inst_o  out  DATA_W  instruction of head entry.
- fq_count_o  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - pc<=RESET_PC, rom_ce_o<=0, queue emptied, id_valid_o=0, id_pc_o=0, id_inst_o=ZeroWord, fq_count_o=0.
  - State <= IDLE.
- States:
  - IDLE: rom_ce_o=0. Next cycle go to FETCH, rom_ce_o<=1.
  - FETCH: normal fetch.
  - STALL: entered when stall_i=1 in FETCH; left on the first cycle stall_i=0.
  - rom_ce_o stays 1 in STALL; pc holds.
- Push condition: state==FETCH && !stall_i && !flush_i && !branch_flag_i && (count<DEPTH || pop).
  - On push: entry {pc, rom_inst_i} is written at the tail and pc<=pc+4 (mod 2^ADDR_W; 0xFFFF_FFFC wraps to 0).
  - Queue full with no pop: no push, pc holds, rom_addr_o stays stable.
- Pop condition: id_valid_o && id_ready_i; the head advances.
  - Push and pop in the same cycle: count unchanged; legal when full or empty.
  - Empty and push: entry appears at the head in the next cycle (latency 1 from rom_addr_o to id_valid_o).
  - No combinational bypass.
- Redirect:
  - flush_i=1: pc<=new_pc_i.
  - Else branch_flag_i=1: pc<=branch_target_addr_i.
  - In both cases: queue cleared (count<=0, pointers<=0, id_valid_o<=0 next cycle), no push that cycle, a concurrent pop is ignored, state<=FETCH.
  - Redirect takes priority over stall_i. Any STALL is exited to FETCH.
- Priority: rst > flush_i > branch_flag_i > stall_i > push/pop.
- Pointers are clog2(DEPTH) bits and wrap naturally. Count saturates logically at DEPTH; overflow and underflow are impossible by construction.
- Outputs are registered head contents. id_pc_o/id_inst_o hold their values while id_valid_o=1 && !id_ready_i.
- Reset mid-operation discards all entries and any pending redirect.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- With macro:
  - Extra output id_excpt_o (1 bit, reset 0).
  - A redirect target with [1:0]!=2'b00 performs no ROM read (rom_ce_o=0).
  - One entry is pushed: {target, ZeroWord}, with excpt=1.
  - State moves to IDLE-halt until the next flush_i.
  - Aligned fetches carry excpt=0.
- Without macro:
  - No id_excpt_o port.
  - Redirect targets have bits [1:0] forced to 2'b00.

Decomposition:
- Shared defines (defines.v): InstAddrBus, InstBus, ZeroWord, ChipEnable/ChipDisable, RstEnable, and the fetch state encodings IF_IDLE/IF_FETCH/IF_STALL.
- One sub-module, fetch_fifo: parameterised DEPTH × (ADDR_W+DATA_W[+1]) synchronous FIFO with push, pop, clear and count.
- inst_fetch holds the PC, the state machine and the redirect priority.

Test Plan:
- Reset, then free-run with id_ready_i=1 → rom_ce_o=1 from cycle 2; id_pc_o sequence 0,4,8,…; one instruction per cycle after 1-cycle latency.
- id_ready_i=0 for 10 cycles → fq_count_o reaches 4, pc frozen at 0x10, no lost or duplicated entries when ready returns.
- branch_flag_i=1 with target 0x100 while count=3 → next cycle id_valid_o=0, count=0; following entries at 0x100, 0x104.
- flush_i (new_pc_i=0x180) and branch_flag_i (0x200) in the same cycle during stall_i=1 → fetch resumes at 0x180.
- PC 0xFFFF_FFFC pushed → next fetch address 0x0000_0000.
- With IF_ALIGN_CHECK_EN, branch to 0x102 → single entry {0x102, 0x0} with id_excpt_o=1, rom_ce_o=0 until flush_i.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the
// all-zero instruction word, chip-enable / reset levels and fetch states.
package inst_fetch_pkg;

  localparam int          INST_ADDR_BUS_W = 32;
  localparam int          INST_BUS_W      = 32;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic        CHIP_ENABLE     = 1'b1;
  localparam logic        CHIP_DISABLE    = 1'b0;
  localparam logic        RST_ENABLE      = 1'b1;

  // IF_HALT is only reachable when misaligned-target trapping is built in.
  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_STALL = 2'b10,
    IF_HALT  = 2'b11
  } if_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Fetch queue: DEPTH-entry synchronous FIFO with push, pop, clear and an
// occupancy count. A clear wins over a pop; a push that coincides with a
// clear lands in slot 0 so the queue restarts holding exactly that entry.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en_s;
  logic             push_en_s;

  assign pop_en_s  = pop_i && (count_q != {CNT_W{1'b0}});
  assign push_en_s = push_i && ((count_q != CNT_W'(DEPTH)) || pop_en_s);

  // Next pointers, count and storage contents from push/pop/clear.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      if (push_i) begin
        mem_d[{PTR_W{1'b0}}] = wr_data_i;
        wr_ptr_d             = PTR_W'(1'b1);
        count_d              = CNT_W'(1'b1);
      end else begin
        wr_ptr_d = {PTR_W{1'b0}};
        count_d  = {CNT_W{1'b0}};
      end
    end else begin
      if (push_en_s) begin
        mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != {CNT_W{1'b0}});
  assign count_o   = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC generation, ROM request and {pc, inst} fetch queue
// toward decode, with stall, branch redirect and exception flush.
// Optional macro IF_ALIGN_CHECK_EN: misaligned redirect targets are trapped
// (one excepting entry, ROM disabled, halt until the next flush) and the
// id_excpt_o port is added. Without it, target bits [1:0] are cleared.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                DATA_W   = INST_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
  localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_addr_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
`ifdef IF_ALIGN_CHECK_EN
  output logic              id_excpt_o,
`endif
  output logic [CNT_W-1:0]  fq_count_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);
`ifdef IF_ALIGN_CHECK_EN
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2'b11));
`endif

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rom_ce_q, rom_ce_d;

  logic              redirect_s;
  logic [ADDR_W-1:0] redir_raw_s;
  logic [ADDR_W-1:0] redir_tgt_s;
  logic              push_s;
  logic              pop_s;
  logic              clear_s;
  logic              full_s;
  logic [ENTRY_W-1:0] wr_data_s;
  logic [ENTRY_W-1:0] rd_data_s;
  logic              fifo_valid_s;
  logic [CNT_W-1:0]  count_s;
  logic [ADDR_W-1:0] head_pc_s;
  logic [DATA_W-1:0] head_inst_s;

  // A halted fetch unit only listens to flush; branches are ignored there.
  assign redirect_s  = flush_i || (branch_flag_i && (state_q != IF_HALT));
  assign redir_raw_s = flush_i ? new_pc_i : branch_target_addr_i;
`ifdef IF_ALIGN_CHECK_EN
  assign redir_tgt_s = redir_raw_s;
`else
  assign redir_tgt_s = redir_raw_s & ALIGN_MASK;
`endif

  assign pop_s  = fifo_valid_s && id_ready_i;
  assign full_s = (count_s == CNT_W'(DEPTH));

  // Next state, next PC and queue commands; redirect outranks stall/fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push_s   = 1'b0;
    clear_s  = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    wr_data_s = {pc_q, rom_inst_i, 1'b0};
`else
    wr_data_s = {pc_q, rom_inst_i};
`endif
    if (redirect_s) begin
      clear_s = 1'b1;
      pc_d    = redir_tgt_s;
      state_d = IF_FETCH;
`ifdef IF_ALIGN_CHECK_EN
      if (redir_tgt_s[1:0] != 2'b00) begin
        push_s    = 1'b1;
        wr_data_s = {redir_tgt_s, DATA_W'(ZERO_WORD), 1'b1};
        state_d   = IF_HALT;
      end else begin
        push_s = 1'b0;
      end
`endif
    end else begin
      case (state_q)
        IF_IDLE: begin
          state_d = IF_FETCH;
        end
        IF_FETCH: begin
          if (stall_i) begin
            state_d = IF_STALL;
          end else if (!full_s || pop_s) begin
            push_s = 1'b1;
            pc_d   = pc_q + PC_STEP;
          end else begin
            pc_d = pc_q;
          end
        end
        IF_STALL: begin
          if (!stall_i) begin
            state_d = IF_FETCH;
          end else begin
            state_d = IF_STALL;
          end
        end
        IF_HALT: begin
          state_d = IF_HALT;
        end
        default: begin
          state_d = IF_IDLE;
        end
      endcase
    end
    rom_ce_d = ((state_d == IF_FETCH) || (state_d == IF_STALL)) ? CHIP_ENABLE : CHIP_DISABLE;
  end

  // State, PC and ROM-enable registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= IF_IDLE;
      pc_q     <= RESET_PC;
      rom_ce_q <= CHIP_DISABLE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rom_ce_q <= rom_ce_d;
    end
  end

  inst_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear_s),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .wr_data_i (wr_data_s),
    .rd_data_o (rd_data_s),
    .valid_o   (fifo_valid_s),
    .count_o   (count_s)
  );

`ifdef IF_ALIGN_CHECK_EN
  logic head_excpt_s;
  assign {head_pc_s, head_inst_s, head_excpt_s} = rd_data_s;
  assign id_excpt_o = fifo_valid_s && head_excpt_s;
`else
  assign {head_pc_s, head_inst_s} = rd_data_s;
`endif

  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = pc_q;
  assign id_valid_o = fifo_valid_s;
  assign id_pc_o    = fifo_valid_s ? head_pc_s : ADDR_W'(ZERO_WORD);
  assign id_inst_o  = fifo_valid_s ? head_inst_s : DATA_W'(ZERO_WORD);
  assign fq_count_o = count_s;

endmodule
